// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: instruction/data cache miss ports and the shared main-memory port.
interface memory_arbiter_if #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
);
    logic               i_mem_read;
    logic [ADDR_W-1:0]  i_mem_address;
    logic [BLOCK_W-1:0] i_mem_readdata;
    logic               i_mem_busywait;
    logic               d_mem_read;
    logic               d_mem_write;
    logic [ADDR_W-1:0]  d_mem_address;
    logic [BLOCK_W-1:0] d_mem_writedata;
    logic [BLOCK_W-1:0] d_mem_readdata;
    logic               d_mem_busywait;
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    modport slave (
        input  i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_address,
               d_mem_writedata, mem_readdata, mem_busywait,
        output i_mem_readdata, i_mem_busywait, d_mem_readdata, d_mem_busywait,
               mem_read, mem_write, mem_address, mem_writedata
    );
    modport master (
        output i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_address,
               d_mem_writedata, mem_readdata, mem_busywait,
        input  i_mem_readdata, i_mem_busywait, d_mem_readdata, d_mem_busywait,
               mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: merges I-cache and D-cache block requests onto one main-memory port.
module memory_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128,
    parameter bit RR_EN   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t             state, state_nx;
    // owner/last: 1 = data cache; op_q: 1 = write
    logic               owner, last, op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q, rdata_q;
    logic               i_req, d_req, grant, grant_d, active;
    assign i_req  = bus.i_mem_read;
    assign d_req  = bus.d_mem_read | bus.d_mem_write;
    assign active = (state == ISSUE) || (state == WAIT);
    always_comb begin
        grant_d  = d_req & (~i_req | ~RR_EN | ~last);
        grant    = (i_req | d_req) & ~bus.mem_busywait;
        state_nx = state == IDLE  ? (grant ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (bus.mem_busywait ? WAIT : DONE) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            last    <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && grant) begin
                owner   <= grant_d;
                op_q    <= grant_d & bus.d_mem_write;
                addr_q  <= grant_d ? bus.d_mem_address : bus.i_mem_address;
                wdata_q <= bus.d_mem_writedata;
            end
            if (state == WAIT && !bus.mem_busywait && !op_q) rdata_q <= bus.mem_readdata;
            if (state == DONE) last <= owner;
        end
    end
    assign bus.mem_read       = active & ~op_q;
    assign bus.mem_write      = active & op_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.i_mem_busywait = i_req & ~(state == DONE && !owner);
    assign bus.d_mem_busywait = d_req & ~(state == DONE && owner);
    assign bus.i_mem_readdata = rdata_q;
    assign bus.d_mem_readdata = rdata_q;
endmodule
